// File: rtl/pipeline_stall_ctrl.sv
// Pipeline advance/stall/flush controller for the five-stage LC-3b pipeline.
// Drives register load enables, bubbles, flushes and memory request gating.
module pipeline_stall_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_resp,
  input  logic             dmem_req,
  input  logic             dmem_resp,
  input  logic             ex_mem_read,
  input  logic [2:0]       ex_dest,
  input  logic [2:0]       id_sr1,
  input  logic [2:0]       id_sr2,
  input  logic             id_uses_sr1,
  input  logic             id_uses_sr2,
  input  logic             branch_taken,
  output logic             imem_read,
  output logic             dmem_en,
  output logic             load_pc,
  output logic             load_if_id,
  output logic             load_id_ex,
  output logic             load_ex_mem,
  output logic             load_mem_wb,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
    logic bubble;
    logic fl_if_id;
    logic fl_id_ex;
    logic fl_ex_mem;
  } ctrl_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic ifetch_done_q, ifetch_done_d;
  logic dmem_done_q, dmem_done_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic i_ok, d_ok, advance;
  logic hz, flush_mode, lu_mode;
  ctrl_t ctrl;

  // Handshake completion: a response counts in its own cycle or once captured.
  always_comb begin
    i_ok      = imem_resp | ifetch_done_q;
    d_ok      = ~dmem_req | dmem_resp | dmem_done_q;
    advance   = i_ok & d_ok & ~reset;
    imem_read = ~reset & ~ifetch_done_q;
    dmem_en   = ~reset & dmem_req & ~dmem_done_q;
  end

  // Load-use hazard between the load in EX and the sources read in ID.
  always_comb begin
    hz = ex_mem_read &
         ((id_uses_sr1 & (id_sr1 == ex_dest)) |
          (id_uses_sr2 & (id_sr2 == ex_dest)));
    flush_mode = advance & branch_taken;
    lu_mode    = advance & hz & ~branch_taken;
  end

  // Mode decode: freeze beats flush beats load-use beats normal.
  always_comb begin
    ctrl = '0;
    unique case (1'b1)
      ~advance: begin
        ctrl = '0;
      end
      flush_mode: begin
        ctrl.pc        = 1'b1;
        ctrl.if_id     = 1'b1;
        ctrl.id_ex     = 1'b1;
        ctrl.ex_mem    = 1'b1;
        ctrl.mem_wb    = 1'b1;
        ctrl.fl_if_id  = 1'b1;
        ctrl.fl_id_ex  = 1'b1;
        ctrl.fl_ex_mem = 1'b1;
      end
      lu_mode: begin
        ctrl.id_ex  = 1'b1;
        ctrl.ex_mem = 1'b1;
        ctrl.mem_wb = 1'b1;
        ctrl.bubble = 1'b1;
      end
      default: begin
        ctrl.pc     = 1'b1;
        ctrl.if_id  = 1'b1;
        ctrl.id_ex  = 1'b1;
        ctrl.ex_mem = 1'b1;
        ctrl.mem_wb = 1'b1;
      end
    endcase
  end

  // Drive the pipeline register controls from the decoded mode.
  always_comb begin
    load_pc      = ctrl.pc;
    load_if_id   = ctrl.if_id;
    load_id_ex   = ctrl.id_ex;
    load_ex_mem  = ctrl.ex_mem;
    load_mem_wb  = ctrl.mem_wb;
    bubble_id_ex = ctrl.bubble;
    flush_if_id  = ctrl.fl_if_id;
    flush_id_ex  = ctrl.fl_id_ex;
    flush_ex_mem = ctrl.fl_ex_mem;
    stall_cycles = stall_q;
    flush_count  = flush_q;
  end

  // Capture early responses so they are neither lost nor re-requested.
  always_comb begin
    ifetch_done_d = ifetch_done_q;
    dmem_done_d   = dmem_done_q;
    if (reset || advance) begin
      ifetch_done_d = 1'b0;
      dmem_done_d   = 1'b0;
    end else begin
      if (imem_resp) ifetch_done_d = 1'b1;
      if (dmem_resp && dmem_req) dmem_done_d = 1'b1;
    end
  end

  // Saturating counters for frozen cycles and branch flushes.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (reset) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (!advance && !(&stall_q)) stall_d = stall_q + CNT_ONE;
      if (flush_mode && !(&flush_q)) flush_d = flush_q + CNT_ONE;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    ifetch_done_q <= ifetch_done_d;
    dmem_done_q   <= dmem_done_d;
    stall_q       <= stall_d;
    flush_q       <= flush_d;
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed-vector bench for pipeline_stall_ctrl.
// Table vectors plus hand-written multi-cycle sequences.
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, imem_resp, dmem_req, dmem_resp, ex_mem_read;
  logic [2:0] ex_dest, id_sr1, id_sr2;
  logic id_uses_sr1, id_uses_sr2, branch_taken;

  logic imem_read, dmem_en, load_pc, load_if_id, load_id_ex;
  logic load_ex_mem, load_mem_wb, bubble_id_ex;
  logic flush_if_id, flush_id_ex, flush_ex_mem;
  logic [15:0] stall_cycles, flush_count;

  logic s_imem_read, s_dmem_en, s_load_pc, s_load_if_id, s_load_id_ex;
  logic s_load_ex_mem, s_load_mem_wb, s_bubble_id_ex;
  logic s_flush_if_id, s_flush_id_ex, s_flush_ex_mem;
  logic [3:0] s_stall_cycles, s_flush_count;

  pipeline_stall_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
    .id_sr1(id_sr1), .id_sr2(id_sr2),
    .id_uses_sr1(id_uses_sr1), .id_uses_sr2(id_uses_sr2),
    .branch_taken(branch_taken),
    .imem_read(imem_read), .dmem_en(dmem_en),
    .load_pc(load_pc), .load_if_id(load_if_id),
    .load_id_ex(load_id_ex), .load_ex_mem(load_ex_mem),
    .load_mem_wb(load_mem_wb), .bubble_id_ex(bubble_id_ex),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .flush_ex_mem(flush_ex_mem),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  pipeline_stall_ctrl #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .imem_resp(imem_resp),
    .dmem_req(dmem_req), .dmem_resp(dmem_resp),
    .ex_mem_read(ex_mem_read), .ex_dest(ex_dest),
    .id_sr1(id_sr1), .id_sr2(id_sr2),
    .id_uses_sr1(id_uses_sr1), .id_uses_sr2(id_uses_sr2),
    .branch_taken(branch_taken),
    .imem_read(s_imem_read), .dmem_en(s_dmem_en),
    .load_pc(s_load_pc), .load_if_id(s_load_if_id),
    .load_id_ex(s_load_id_ex), .load_ex_mem(s_load_ex_mem),
    .load_mem_wb(s_load_mem_wb), .bubble_id_ex(s_bubble_id_ex),
    .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex),
    .flush_ex_mem(s_flush_ex_mem),
    .stall_cycles(s_stall_cycles), .flush_count(s_flush_count)
  );

  // {imem_read, dmem_en, pc, if_id, id_ex, ex_mem, mem_wb,
  //  bubble, fl_if_id, fl_id_ex, fl_ex_mem}
  localparam logic [10:0] O_RST  = 11'b00_00000_0_000;
  localparam logic [10:0] O_NORM = 11'b10_11111_0_000;
  localparam logic [10:0] O_FRZ  = 11'b10_00000_0_000;
  localparam logic [10:0] O_LU   = 11'b10_00111_1_000;
  localparam logic [10:0] O_FL   = 11'b10_11111_0_111;

  typedef struct {
    logic       rst;
    logic       ir;
    logic       dq;
    logic       dr;
    logic       exr;
    logic [2:0] dst;
    logic [2:0] s1;
    logic [2:0] s2;
    logic       u1;
    logic       u2;
    logic       br;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[14];
  int checks = 0;
  int failures = 0;
  int exp_stall, exp_flush;
  logic [10:0] ov;

  always_comb ov = {imem_read, dmem_en, load_pc, load_if_id,
                    load_id_ex, load_ex_mem, load_mem_wb,
                    bubble_id_ex, flush_if_id, flush_id_ex,
                    flush_ex_mem};

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
    ex_mem_read = 0; ex_dest = 0; id_sr1 = 0; id_sr2 = 0;
    id_uses_sr1 = 0; id_uses_sr2 = 0; branch_taken = 0;
  endtask

  task automatic do_reset();
    next_cycle();
    idle_inputs();
    reset = 1;
    next_cycle();
    reset = 0;
  endtask

  function automatic vec_t mk(input logic rst, input logic ir,
      input logic dq, input logic dr, input logic exr,
      input logic [2:0] dst, input logic [2:0] s1,
      input logic [2:0] s2, input logic u1, input logic u2,
      input logic br, input logic [10:0] exp);
    vec_t v;
    v.rst = rst; v.ir = ir; v.dq = dq; v.dr = dr; v.exr = exr;
    v.dst = dst; v.s1 = s1; v.s2 = s2; v.u1 = u1; v.u2 = u2;
    v.br = br; v.exp = exp;
    return v;
  endfunction

  initial begin
    idle_inputs();
    vecs[0]  = mk(0,1,0,0, 0,0,0,0,0,0, 0, O_NORM);
    vecs[1]  = mk(0,0,0,0, 0,0,0,0,0,0, 0, O_FRZ);
    vecs[2]  = mk(0,0,1,0, 0,0,0,0,0,0, 0, 11'b11_00000_0_000);
    vecs[3]  = mk(0,1,1,1, 0,0,0,0,0,0, 0, 11'b11_11111_0_000);
    vecs[4]  = mk(0,1,0,1, 0,0,0,0,0,0, 0, O_NORM);
    vecs[5]  = mk(0,1,0,0, 1,3,0,3,0,1, 0, O_LU);
    vecs[6]  = mk(0,1,0,0, 1,3,0,3,0,0, 0, O_NORM);
    vecs[7]  = mk(0,1,0,0, 1,5,5,0,1,0, 0, O_LU);
    vecs[8]  = mk(0,1,0,0, 0,5,5,0,1,0, 0, O_NORM);
    vecs[9]  = mk(0,1,0,0, 1,5,4,0,1,0, 0, O_NORM);
    vecs[10] = mk(0,1,0,0, 1,3,0,3,0,1, 1, O_FL);
    vecs[11] = mk(0,1,0,0, 0,0,0,0,0,0, 1, O_FL);
    vecs[12] = mk(0,0,0,0, 1,3,0,3,0,1, 1, O_FRZ);
    vecs[13] = mk(1,1,1,0, 1,3,0,3,0,1, 1, O_RST);

    // Reset then a single fetch on the 3rd cycle.
    next_cycle();
    reset = 1;
    #4 chk("rst1_out", ov, O_RST);
    next_cycle();
    #4 chk("rst2_out", ov, O_RST);
    chk("rst_stall", stall_cycles, 0);
    chk("rst_flush", flush_count, 0);
    next_cycle();
    reset = 0; imem_resp = 1;
    #4 chk("fetch_c3_out", ov, O_NORM);
    chk("fetch_c3_stall", stall_cycles, 0);
    next_cycle();
    imem_resp = 0;
    #4 chk("fetch_c4_out", ov, O_FRZ);
    chk("fetch_c4_stall", stall_cycles, 0);

    // Table vectors, starting from clean flags and counters.
    do_reset();
    exp_stall = 0;
    exp_flush = 0;
    foreach (vecs[i]) begin
      if (i != 0) next_cycle();
      reset = vecs[i].rst; imem_resp = vecs[i].ir;
      dmem_req = vecs[i].dq; dmem_resp = vecs[i].dr;
      ex_mem_read = vecs[i].exr; ex_dest = vecs[i].dst;
      id_sr1 = vecs[i].s1; id_sr2 = vecs[i].s2;
      id_uses_sr1 = vecs[i].u1; id_uses_sr2 = vecs[i].u2;
      branch_taken = vecs[i].br;
      #4;
      chk($sformatf("vec%0d_out", i), ov, vecs[i].exp);
      chk($sformatf("vec%0d_stall", i), stall_cycles, exp_stall);
      chk($sformatf("vec%0d_flush", i), flush_count, exp_flush);
      if (vecs[i].rst) begin
        exp_stall = 0;
        exp_flush = 0;
      end else begin
        if (!vecs[i].exp[6]) exp_stall++;
        if (vecs[i].exp[2]) exp_flush++;
      end
    end
    next_cycle();
    idle_inputs();
    #4 chk("post_tbl_stall", stall_cycles, 0);
    chk("post_tbl_flush", flush_count, 0);

    // Split responses: imem at cycle 0, dmem at cycle 4.
    do_reset();
    dmem_req = 1; imem_resp = 1;
    #4 chk("split_c0_out", ov, 11'b11_00000_0_000);
    for (int c = 1; c <= 3; c++) begin
      next_cycle();
      imem_resp = 0;
      #4 chk($sformatf("split_c%0d_out", c), ov, 11'b01_00000_0_000);
    end
    next_cycle();
    dmem_resp = 1;
    #4 chk("split_c4_out", ov, 11'b01_11111_0_000);
    next_cycle();
    dmem_resp = 0;
    #4 chk("split_c5_out", ov, 11'b11_00000_0_000);
    chk("split_c5_stall", stall_cycles, 4);

    // Data response first, fetch response later.
    do_reset();
    dmem_req = 1; dmem_resp = 1;
    #4 chk("drev_c0_out", ov, 11'b11_00000_0_000);
    next_cycle();
    dmem_resp = 0;
    #4 chk("drev_c1_out", ov, 11'b10_00000_0_000);
    next_cycle();
    imem_resp = 1;
    #4 chk("drev_c2_out", ov, 11'b10_11111_0_000);
    next_cycle();
    imem_resp = 0;
    #4 chk("drev_c3_out", ov, 11'b11_00000_0_000);

    // Branch beats hazard, flush counted once.
    do_reset();
    imem_resp = 1; ex_mem_read = 1; ex_dest = 3;
    id_sr2 = 3; id_uses_sr2 = 1; branch_taken = 1;
    #4 chk("brhz_out", ov, O_FL);
    next_cycle();
    branch_taken = 0;
    #4 chk("brhz_count", flush_count, 1);
    chk("brhz_lu_out", ov, O_LU);

    // Counter saturation on the narrow instance.
    do_reset();
    for (int c = 0; c < 20; c++) next_cycle();
    #4 chk("sat_small", s_stall_cycles, 15);
    chk("sat_wide", stall_cycles, 20);

    // Reset mid-stall drops outstanding requests.
    do_reset();
    dmem_req = 1; imem_resp = 1;
    next_cycle();
    imem_resp = 0;
    #4 chk("rms_c1_out", ov, 11'b01_00000_0_000);
    next_cycle();
    reset = 1;
    #4 chk("rms_c2_out", ov, O_RST);
    next_cycle();
    reset = 0;
    #4 chk("rms_c3_out", ov, 11'b11_00000_0_000);
    chk("rms_c3_stall", stall_cycles, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
